// File: rtl/mult_matrix_prep.sv
// Staircase skew stage in front of the systolic multiplier. Lane k is delayed k cycles.
// Lane 0 (MSB slice) passes straight through; every other lane is a flop chain.
module mult_matrix_prep #(
    parameter int data_size = 16,
    parameter int size      = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [data_size*size-1:0] input_stream,
    output logic [data_size*size-1:0] output_stream
);

    for (genvar k = 0; k < size; k++) begin : g_lane
        localparam int lane_hi = data_size * (size - k) - 1;

        if (k == 0) begin : g_pass
            assign output_stream[lane_hi -: data_size] = input_stream[lane_hi -: data_size];
        end else begin : g_delay
            // stage[0] holds the newest sample; stage[k-1] drives the output directly.
            logic [k-1:0][data_size-1:0] stage = '0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    stage <= '0;
                end else begin
                    stage[0] <= input_stream[lane_hi -: data_size];
                    for (int i = 1; i < k; i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign output_stream[lane_hi -: data_size] = stage[k-1];
        end
    end

endmodule

// File: tb/tb_mult_matrix_prep.sv
// Bench for mult_matrix_prep: three instances (3x16, 1x8, 4x8) driven in lockstep.
// The driver pushes hand-computed expectations; a negedge monitor pops and compares.
module tb_mult_matrix_prep;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [47:0] in3 = '0;
    logic [47:0] out3;
    logic [7:0]  in1 = '0;
    logic [7:0]  out1;
    logic [31:0] in4 = '0;
    logic [31:0] out4;

    always #5 clk = ~clk;

    mult_matrix_prep #(.data_size(16), .size(3)) dut3 (
        .clk(clk), .reset(reset), .input_stream(in3), .output_stream(out3));
    mult_matrix_prep #(.data_size(8), .size(1)) dut1 (
        .clk(clk), .reset(reset), .input_stream(in1), .output_stream(out1));
    mult_matrix_prep #(.data_size(8), .size(4)) dut4 (
        .clk(clk), .reset(reset), .input_stream(in4), .output_stream(out4));

    typedef struct {
        logic [47:0] e3;
        logic [7:0]  e1;
        logic [31:0] e4;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic logic [47:0] pack3(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
        return {a, b, c};
    endfunction

    function automatic logic [31:0] pack4(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
        return {a, b, c, d};
    endfunction

    // Ramp lane value seen at cycle n: input of cycle n-lane, or pre/zero outside the ramp window.
    function automatic logic [15:0] ramp_lane(input int n, input int lane, input int first,
                                              input int last, input logic [15:0] pre);
        int src;
        src = n - lane;
        if (src >= first && src <= last) return 16'(src + 16 * lane);
        if (src < first) return pre;
        return 16'h0000;
    endfunction

    task automatic drive(input logic r, input logic [47:0] i3, input logic [47:0] e3,
                         input logic [7:0] i1, input logic [7:0] e1,
                         input logic [31:0] i4, input logic [31:0] e4, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r;
        in3   = i3;
        in1   = i1;
        in4   = i4;
        e.e3  = e3;
        e.e1  = e1;
        e.e4  = e4;
        e.tag = tag;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (out3 !== e.e3) begin
                n_fail++;
                $display("FAIL %s size3: got %h expected %h", e.tag, out3, e.e3);
            end
            n_checks++;
            if (out1 !== e.e1) begin
                n_fail++;
                $display("FAIL %s size1: got %h expected %h", e.tag, out1, e.e1);
            end
            n_checks++;
            if (out4 !== e.e4) begin
                n_fail++;
                $display("FAIL %s size4: got %h expected %h", e.tag, out4, e.e4);
            end
        end
    end

    initial begin
        logic [47:0] hold;
        logic [47:0] i3;
        logic [47:0] e3;
        logic [31:0] i4;
        logic [31:0] e4;
        int first;

        hold = pack3(16'h0100, 16'h0200, 16'h0300);

        // Reset then hold: reset cycle itself also exposes power-up zeros
        drive(1'b1, hold, pack3(16'h0100, 16'h0, 16'h0), 8'h0, 8'h0, '0, '0, "reset_cycle");
        drive(1'b0, hold, pack3(16'h0100, 16'h0, 16'h0), 8'h0, 8'h0, '0, '0, "hold_c1");
        drive(1'b0, hold, pack3(16'h0100, 16'h0200, 16'h0), 8'h0, 8'h0, '0, '0, "hold_c2");
        drive(1'b0, hold, hold, 8'h0, 8'h0, '0, '0, "hold_c3");
        drive(1'b0, hold, hold, 8'h0, 8'h0, '0, '0, "hold_c4");

        // Ramp; the 3-lane pipeline still holds 0x0200/0x0300 from the hold phase
        for (int n = 1; n <= 10; n++) begin
            i3 = pack3(16'(n), 16'(n + 16), 16'(n + 32));
            e3 = pack3(16'(n), ramp_lane(n, 1, 1, 10, 16'h0200), ramp_lane(n, 2, 1, 10, 16'h0300));
            i4 = pack4(8'(n), 8'(n + 16), 8'(n + 32), 8'(n + 48));
            e4 = pack4(8'(n), 8'(ramp_lane(n, 1, 1, 10, 16'h0)),
                       8'(ramp_lane(n, 2, 1, 10, 16'h0)), 8'(ramp_lane(n, 3, 1, 10, 16'h0)));
            drive(1'b0, i3, e3, 8'(n), 8'(n), i4, e4, "ramp");
        end

        // Zeros drain the ramp tail
        for (int n = 11; n <= 13; n++) begin
            e3 = pack3(16'h0, ramp_lane(n, 1, 1, 10, 16'h0), ramp_lane(n, 2, 1, 10, 16'h0));
            e4 = pack4(8'h0, 8'(ramp_lane(n, 1, 1, 10, 16'h0)),
                       8'(ramp_lane(n, 2, 1, 10, 16'h0)), 8'(ramp_lane(n, 3, 1, 10, 16'h0)));
            drive(1'b0, '0, e3, 8'h0, 8'h0, '0, e4, "ramp_drain");
        end

        // Single-cycle impulse
        drive(1'b0, {48{1'b1}}, pack3(16'hFFFF, 16'h0, 16'h0), 8'hFF, 8'hFF,
              32'hFFFF_FFFF, 32'hFF00_0000, "impulse_t0");
        drive(1'b0, '0, pack3(16'h0, 16'hFFFF, 16'h0), 8'h0, 8'h0, '0, 32'h00FF_0000, "impulse_t1");
        drive(1'b0, '0, pack3(16'h0, 16'h0, 16'hFFFF), 8'h0, 8'h0, '0, 32'h0000_FF00, "impulse_t2");
        drive(1'b0, '0, '0, 8'h0, 8'h0, '0, 32'h0000_00FF, "impulse_t3");
        drive(1'b0, '0, '0, 8'h0, 8'h0, '0, '0, "impulse_t4");

        // Ramp with reset asserted during cycle 6: delayed lanes restart from cycle 7 input
        for (int n = 1; n <= 13; n++) begin
            first = (n >= 7) ? 7 : 1;
            if (n <= 10) begin
                i3 = pack3(16'(n), 16'(n + 16), 16'(n + 32));
                i4 = pack4(8'(n), 8'(n + 16), 8'(n + 32), 8'(n + 48));
            end else begin
                i3 = '0;
                i4 = '0;
            end
            e3 = pack3(i3[47:32], ramp_lane(n, 1, first, 10, 16'h0),
                       ramp_lane(n, 2, first, 10, 16'h0));
            e4 = pack4(i4[31:24], 8'(ramp_lane(n, 1, first, 10, 16'h0)),
                       8'(ramp_lane(n, 2, first, 10, 16'h0)), 8'(ramp_lane(n, 3, first, 10, 16'h0)));
            drive(n == 6, i3, e3, i4[31:24], i4[31:24], i4, e4, "mid_reset");
        end

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mult_matrix_prep.md
Name: mult_matrix_prep

Overview:
- Input-skew ("staircase") stage that feeds a systolic matrix multiplier.
- Takes one packed vector of `size` lanes per clock and delays each lane by its lane index, so lane k leaves k cycles after it arrived.
- In the backprop stack it sits after the elementwise z-to-z product and skews that vector before systolic consumption.

Parameters:
- data_size, 16, bit width of one lane (fixed-point word, treated as opaque bits).
- size, 3, number of lanes; also the skew depth (max delay is size-1 cycles). Legal range is size ≥ 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; clears all delay registers.
- input_stream  input  data_size*size  packed input vector.
- output_stream  output  data_size*size  packed skewed output vector.

Behaviour:
- Lane indexing:
  - Lane k (k = 0..size-1) occupies bits [data_size*(size-k)-1 -: data_size].
  - Lane 0 is the most-significant slice.
  - Input and output use the same lane mapping.
- Lane 0 delay:
  - Zero delay: output lane 0 = input lane 0, purely combinational.
  - Not affected by reset.
- Lane k delay, for k ≥ 1:
  - Shift register of exactly k stages, each data_size bits wide.
  - output lane k at cycle t = input lane k sampled at the rising edge of cycle t-k.
- Total register count is data_size * size*(size-1)/2 bits. Implement with a generate loop per lane.
- Data handling:
  - No arithmetic, saturation or sign handling.
  - Bits pass through unchanged.
- No handshake:
  - A new vector is accepted every clock.
  - Throughput is one vector per cycle and there is no stall input.
- Reset:
  - On a rising edge with reset=1, every delay register loads 0.
  - Consequently output lanes k ≥ 1 read 0 for the cycle after reset.
  - Stages refill one per cycle. Lane k shows the first post-reset input value k cycles after that value's arrival edge; earlier slots read 0.
- Reset mid-stream:
  - Any in-flight data in the delay registers is discarded (zeroed).
  - Input presented during the reset cycle is not captured by delayed lanes.
  - Lane 0 still passes it combinationally.
- Power-up:
  - Registers also initialise to 0 (initial value) so simulation without reset shows 0, never X.
- size = 1:
  - Degenerate case: output_stream = input_stream, no registers.
- Timing:
  - Outputs of lanes k ≥ 1 come directly from flops.
  - Only lane 0 has a combinational input→output path.

Test Plan:
- Reset then hold. Setup: size=3, data_size=16; assert reset one cycle, then hold input lanes (0,1,2) = (0x0100, 0x0200, 0x0300) constant.
  - Required: output = (0x0100, 0x0000, 0x0000) in cycle 1, (0x0100, 0x0200, 0x0000) in cycle 2, (0x0100, 0x0200, 0x0300) from cycle 3 onward.
- Ramp skew. Drive the vector (n, n+16, n+32) on cycle n for n = 1..10.
  - Required: at cycle t, lane 0 = t, lane 1 = (t-1)+16, lane 2 = (t-2)+32, i.e. at t=5 the output is (5, 20, 35).
- Single-cycle impulse. Setup: lanes all 0 except one cycle with all lanes = 0xFFFF.
  - Required: lane 0 pulses in the same cycle, lane 1 one cycle later, lane 2 two cycles later; each pulse is exactly one cycle wide.
- Reset mid-stream. Run the ramp, then assert reset at cycle 6 for one cycle.
  - Required: the cycle after reset shows lanes 1 and 2 = 0.
  - Lane 0 continues to track the input combinationally.
  - Lane 1 recovers after 1 further cycle and lane 2 after 2.
- Parameter sweep: size=1, size=4, data_size=8, with the same ramp stimulus.
  - size=1: output equals input every cycle.
  - size=4: lane 3 lags its input by exactly 3 cycles.
  - No X on any output bit after reset or power-up.
